// File: rtl/countdown_controller_pkg.sv
// rtl/countdown_controller_pkg.sv - shared state encoding, defaults and 7-seg decode for the countdown controller
package countdown_controller_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int DEBOUNCE_DEFAULT = 500000;
  localparam int CNT_W_DEFAULT    = 19;

  // Active-low segments packed as {g,f,e,d,c,b,a}
  function automatic logic [6:0] hexa7seg(input logic [3:0] value);
    logic [6:0] seg;
    case (value)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'ha: seg = 7'h08;
      4'hb: seg = 7'h03;
      4'hc: seg = 7'h46;
      4'hd: seg = 7'h21;
      4'he: seg = 7'h06;
      default: seg = 7'h0e;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/countdown_controller_key_conditioner.sv
// rtl/countdown_controller_key_conditioner.sv - key synchronizer, debouncer and rising-edge pulse
module key_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 19
) (
  input  logic clock,
  input  logic reset,
  input  logic key,
  output logic pulse
);

  logic             sync1;
  logic             sync2;
  logic             level;
  logic [CNT_W-1:0] cnt;

  // The pulse is raised on the same edge the debounced level rises, so it is
  // visible for exactly one cycle right after the level is accepted.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
      pulse <= 1'b0;
    end else begin
      sync1 <= key;
      sync2 <= sync1;
      pulse <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        cnt   <= '0;
        level <= sync2;
        pulse <= sync2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/countdown_controller.sv
// rtl/countdown_controller.sv - session controller driving the 1 s countdown timer and counting rounds
module countdown_controller
  import countdown_controller_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int CNT_W           = CNT_W_DEFAULT
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       key_go,
  input  logic       key_pause,
  input  logic [3:0] sw_period,
  input  logic [3:0] sw_rounds,
  input  logic       timer_finished,
  output logic [3:0] timer_period,
  output logic       timer_start,
  output logic       timer_reset,
  output logic [3:0] rounds_done,
  output logic [6:0] hex_rounds,
  output logic       led_running,
  output logic       led_paused,
  output logic       led_all_done
);

  state_t     state;
  state_t     state_next;
  logic [3:0] target;
  logic [3:0] target_next;
  logic [3:0] period_next;
  logic [3:0] rounds_next;
  logic       fin_q;
  logic       fin_rise;
  logic       go_pulse;
  logic       pause_pulse;

  key_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_key_go (
    .clock (clock),
    .reset (reset),
    .key   (key_go),
    .pulse (go_pulse)
  );

  key_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_key_pause (
    .clock (clock),
    .reset (reset),
    .key   (key_pause),
    .pulse (pause_pulse)
  );

  assign fin_rise   = timer_finished & ~fin_q;
  assign hex_rounds = hexa7seg(rounds_done);

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= ST_IDLE;
      target       <= '0;
      timer_period <= '0;
      rounds_done  <= '0;
      fin_q        <= 1'b0;
      timer_start  <= 1'b0;
      timer_reset  <= 1'b1;
      led_running  <= 1'b0;
      led_paused   <= 1'b0;
      led_all_done <= 1'b0;
    end else begin
      state        <= state_next;
      target       <= target_next;
      timer_period <= period_next;
      rounds_done  <= rounds_next;
      fin_q        <= timer_finished;
      timer_start  <= (state_next == ST_RUN);
      timer_reset  <= (state_next == ST_IDLE);
      led_running  <= (state_next == ST_RUN);
      led_paused   <= (state_next == ST_PAUSE);
      led_all_done <= (state_next == ST_DONE);
    end
  end

  always_comb begin
    state_next  = state;
    target_next = target;
    period_next = timer_period;
    rounds_next = rounds_done;
    case (state)
      ST_IDLE: begin
        period_next = sw_period;
        if (go_pulse && (sw_period != 4'd0) && (sw_rounds != 4'd0)) begin
          state_next  = ST_RUN;
          target_next = sw_rounds;
          rounds_next = 4'd0;
        end
      end
      ST_RUN: begin
        // A finish coinciding with pause is counted first; reaching the target beats pausing.
        if (fin_rise) begin
          rounds_next = rounds_done + 4'd1;
          if (rounds_next == target) begin
            state_next = ST_DONE;
          end else if (pause_pulse) begin
            state_next = ST_PAUSE;
          end
        end else if (pause_pulse) begin
          state_next = ST_PAUSE;
        end
      end
      ST_PAUSE: begin
        if (go_pulse || pause_pulse) begin
          state_next = ST_RUN;
        end
      end
      default: begin
        if (go_pulse) begin
          state_next  = ST_IDLE;
          rounds_next = 4'd0;
        end
      end
    endcase
  end

endmodule

// File: tb/tb_countdown_controller.sv
// tb/tb_countdown_controller.sv - self-checking bench for countdown_controller with a session-level model
module tb_countdown_controller;

  localparam int DB = 4;

  logic       clock = 1'b0;
  logic       reset;
  logic       key_go;
  logic       key_pause;
  logic [3:0] sw_period;
  logic [3:0] sw_rounds;
  logic       timer_finished;
  logic [3:0] timer_period;
  logic       timer_start;
  logic       timer_reset;
  logic [3:0] rounds_done;
  logic [6:0] hex_rounds;
  logic       led_running;
  logic       led_paused;
  logic       led_all_done;

  int n_checks = 0;
  int n_pass   = 0;

  countdown_controller #(.DEBOUNCE_CYCLES(DB), .CNT_W(19)) dut (
    .clock          (clock),
    .reset          (reset),
    .key_go         (key_go),
    .key_pause      (key_pause),
    .sw_period      (sw_period),
    .sw_rounds      (sw_rounds),
    .timer_finished (timer_finished),
    .timer_period   (timer_period),
    .timer_start    (timer_start),
    .timer_reset    (timer_reset),
    .rounds_done    (rounds_done),
    .hex_rounds     (hex_rounds),
    .led_running    (led_running),
    .led_paused     (led_paused),
    .led_all_done   (led_all_done)
  );

  always #5 clock = ~clock;

  function automatic logic [6:0] seg_of(input logic [3:0] v);
    logic [6:0] t [16];
    t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
          7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0e};
    return t[v];
  endfunction

  task automatic chk(input string name, input logic [19:0] got, input logic [19:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
  endtask

  // Session model: mode 0 idle, 1 running, 2 paused, 3 done.
  int         m_mode;
  bit         m_valid = 1'b0;
  logic [3:0] m_period, m_target, m_rd;
  logic [5:0] go_hist, pa_hist;
  bit         go_lvl, pa_lvl, go_p, pa_p, m_finq, fr;

  always @(posedge clock) begin
    if (reset) begin
      m_mode = 0; m_period = 0; m_target = 0; m_rd = 0;
      go_hist = 0; pa_hist = 0; go_lvl = 0; pa_lvl = 0;
      go_p = 0; pa_p = 0; m_finq = 0; m_valid = 1'b1;
    end else begin
      fr     = timer_finished && !m_finq;
      m_finq = timer_finished;
      if (m_mode == 0) begin
        m_period = sw_period;
        if (go_p && sw_period != 0 && sw_rounds != 0) begin
          m_mode = 1; m_target = sw_rounds; m_rd = 0;
        end
      end else if (m_mode == 1) begin
        if (fr) m_rd = m_rd + 1;
        if (fr && m_rd == m_target) m_mode = 3;
        else if (pa_p) m_mode = 2;
      end else if (m_mode == 2) begin
        if (go_p || pa_p) m_mode = 1;
      end else if (go_p) begin
        m_mode = 0; m_rd = 0;
      end
      // A key level flips once the synchronised key has disagreed with it for DB samples in a row.
      go_hist = {go_hist[4:0], key_go};
      pa_hist = {pa_hist[4:0], key_pause};
      go_p = 0;
      pa_p = 0;
      if (go_hist[5:2] == {4{~go_lvl}}) begin go_lvl = !go_lvl; go_p = go_lvl; end
      if (pa_hist[5:2] == {4{~pa_lvl}}) begin pa_lvl = !pa_lvl; pa_p = pa_lvl; end
    end
  end

  always @(negedge clock) begin
    if (m_valid) begin
      chk("cycle_outputs",
          {timer_period, timer_start, timer_reset, rounds_done, hex_rounds,
           led_running, led_paused, led_all_done},
          {m_period, m_mode == 1, m_mode == 0, m_rd, seg_of(m_rd),
           m_mode == 1, m_mode == 2, m_mode == 3});
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic press(input bit is_go, input int hold);
    if (is_go) key_go = 1'b1; else key_pause = 1'b1;
    tick(hold);
    key_go = 1'b0;
    key_pause = 1'b0;
    tick(8);
  endtask

  task automatic fin(input int n);
    timer_finished = 1'b1;
    tick(n);
    timer_finished = 1'b0;
    tick(2);
  endtask

  // Lines the finish rise up with the edge that consumes the pause pulse.
  task automatic fin_with_pause();
    key_pause = 1'b1;
    tick(6);
    timer_finished = 1'b1;
    tick(1);
    timer_finished = 1'b0;
    tick(4);
    key_pause = 1'b0;
    tick(8);
  endtask

  initial begin
    reset = 1'b1; key_go = 0; key_pause = 0;
    sw_period = 0; sw_rounds = 0; timer_finished = 0;
    tick(2);
    chk("rst_timer_reset", timer_reset, 1);
    chk("rst_timer_start", timer_start, 0);
    chk("rst_rounds", rounds_done, 0);
    chk("rst_hex", hex_rounds, 7'h40);
    chk("rst_leds", {led_running, led_paused, led_all_done}, 0);
    reset = 1'b0;
    sw_period = 5;
    tick(1);
    chk("idle_tracks_period", timer_period, 5);

    sw_period = 3; sw_rounds = 2;
    press(1, 2);
    chk("glitch_ignored", {led_running, timer_reset}, 2'b01);
    press(1, 10);
    chk("run_start_reset", {timer_start, timer_reset, led_running}, 3'b101);
    chk("run_period", timer_period, 3);
    sw_period = 9;
    tick(2);
    chk("run_period_held", timer_period, 3);

    fin(6);
    chk("long_finish_once", rounds_done, 1);
    chk("hex_one", hex_rounds, 7'h79);
    fin(1);
    chk("done_rounds", rounds_done, 2);
    chk("done_leds", {led_all_done, timer_start}, 2'b10);

    press(1, 10);
    chk("done_to_idle", {led_all_done, timer_reset, rounds_done}, {2'b01, 4'd0});

    sw_rounds = 3;
    press(1, 10);
    press(0, 10);
    chk("paused", {timer_start, led_paused}, 2'b01);
    fin(3);
    chk("paused_fin_ignored", rounds_done, 0);
    press(1, 10);
    chk("resume", led_running, 1);
    fin(1);
    fin_with_pause();
    chk("sim_not_target_pause", {led_paused, rounds_done}, {1'b1, 4'd2});
    press(1, 10);
    fin(1);
    chk("target3_done", {led_all_done, rounds_done}, {1'b1, 4'd3});
    press(1, 10);

    sw_rounds = 2;
    press(1, 10);
    fin(1);
    fin_with_pause();
    chk("sim_target_done", {led_all_done, led_paused, rounds_done}, {2'b10, 4'd2});
    press(1, 10);

    sw_period = 0;
    press(1, 10);
    chk("zero_period_idle", {led_running, timer_reset}, 2'b01);
    sw_period = 4; sw_rounds = 0;
    press(1, 10);
    chk("zero_rounds_idle", {led_running, timer_reset}, 2'b01);

    sw_rounds = 5;
    press(1, 10);
    fin(1);
    key_go = 1'b1;
    reset = 1'b1;
    tick(1);
    chk("mid_reset", {led_running, timer_reset, rounds_done, timer_period}, {2'b01, 4'd0, 4'd0});
    reset = 1'b0;
    tick(10);
    chk("held_through_reset", {led_running, timer_period}, {1'b1, 4'd4});
    key_go = 1'b0;
    tick(8);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
